output_link_allocator: RTL

Wormhole output-port allocator for the virtual channel router. It shares one output link among the four link input ports and the local core. It grants the link to one requester from header flit to tailer flit and issues read strobes to the winning input buffer. Flow control against the downstream buffer uses a credit counter. It sits between the per-input read-enable logic and the output crossbar mux.

---
 rtl/vc_router_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/output_link_allocator.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/vc_router_pkg.sv
// Shared definitions for the virtual channel router: requester indices,
// the output allocator state encoding and the default downstream depth.
package vc_router_pkg;

  localparam int NREQ      = 5;
  localparam int REQ_LINK1 = 0;
  localparam int REQ_LINK2 = 1;
  localparam int REQ_LINK3 = 2;
  localparam int REQ_LINK4 = 3;
  localparam int REQ_CORE  = 4;

  localparam int DEPTH = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches from last_winner+1 upward,
// wrapping modulo NREQ, and returns the first eligible requester.
module rr_arbiter
  import vc_router_pkg::*;
#(
  parameter int NREQ = vc_router_pkg::NREQ,
  parameter int SELW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] eligible,
  input  logic [SELW-1:0] last_winner,
  output logic [NREQ-1:0] winner,
  output logic [SELW-1:0] winner_idx
);

  logic found;
  int   cand;

  always_comb begin
    winner     = '0;
    winner_idx = '0;
    found      = 1'b0;
    cand       = 0;
    for (int off = 1; off <= NREQ; off++) begin
      cand = int'(last_winner) + off;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!found && eligible[cand]) begin
        found          = 1'b1;
        winner[cand]   = 1'b1;
        winner_idx     = SELW'(cand);
      end
    end
  end

endmodule

// File: rtl/output_link_allocator.sv
// Wormhole output-link allocator with credit flow control.
// Optional stall watchdog enabled by defining VC_ALLOC_WATCHDOG_EN.
//
// Handshake: rd[i] is a pop strobe; a flit moves when rd[i] is high at the
// rising edge. rd is only raised when the link is granted to i, req[i] is
// high and at least one downstream credit is available.
module output_link_allocator
  import vc_router_pkg::*;
#(
  parameter int NREQ  = vc_router_pkg::NREQ,
  parameter int DEPTH = vc_router_pkg::DEPTH,
  parameter int CW    = $clog2(DEPTH + 1),
  parameter int SELW  = $clog2(NREQ)
`ifdef VC_ALLOC_WATCHDOG_EN
  ,
  parameter int TIMEOUT = 255
`endif
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] head,
  input  logic [NREQ-1:0] tail,
  input  logic            credit_in,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] rd,
  output logic [SELW-1:0] sel,
  output logic            flit_valid,
  output logic [CW-1:0]   credits,
  output logic            busy,
  output logic            wd_err,
  output state_t          state_dbg,
  output logic [SELW-1:0] last_winner_dbg
);

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [SELW-1:0] lw_q, lw_d;
  logic [CW-1:0]   credits_q;
  logic [NREQ-1:0] arb_winner;
  logic [SELW-1:0] arb_idx;
  logic            release_pkt;
  logic            wd_fire;

  rr_arbiter #(.NREQ(NREQ), .SELW(SELW)) u_arb (
    .eligible   (req & head),
    .last_winner(lw_q),
    .winner     (arb_winner),
    .winner_idx (arb_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      lw_q    <= SELW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      lw_q    <= lw_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    lw_d    = lw_q;
    case (state_q)
      IDLE: begin
        if (|arb_winner) begin
          state_d = BUSY;
          gnt_d   = arb_winner;
          sel_d   = arb_idx;
        end
      end
      BUSY: begin
        if (release_pkt || wd_fire) begin
          state_d = IDLE;
          gnt_d   = '0;
          lw_d    = sel_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // rd comes straight from registered grant/credits so a reset drops it at once.
  always_comb begin
    rd          = '0;
    if (state_q == BUSY && credits_q != '0) rd = gnt_q & req;
    flit_valid  = |rd;
    release_pkt = flit_valid & tail[sel_q];
    busy        = (state_q == BUSY);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      credits_q <= CW'(DEPTH);
    end else if (flit_valid && !credit_in) begin
      credits_q <= credits_q - 1'b1;
    end else if (credit_in && !flit_valid && credits_q != CW'(DEPTH)) begin
      credits_q <= credits_q + 1'b1;
    end
  end

`ifdef VC_ALLOC_WATCHDOG_EN
  logic [7:0] wd_cnt_q;
  logic       wd_err_q;

  assign wd_fire = (state_q == BUSY) && (wd_cnt_q == 8'(TIMEOUT));

  // Any flit or returned credit counts as forward progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt_q <= '0;
      wd_err_q <= 1'b0;
    end else begin
      wd_err_q <= wd_fire;
      if (state_q != BUSY || flit_valid || credit_in || wd_fire) wd_cnt_q <= '0;
      else wd_cnt_q <= wd_cnt_q + 8'd1;
    end
  end

  assign wd_err = wd_err_q;
`else
  assign wd_fire = 1'b0;
  assign wd_err  = 1'b0;
`endif

  assign gnt             = gnt_q;
  assign sel             = sel_q;
  assign credits         = credits_q;
  assign state_dbg       = state_q;
  assign last_winner_dbg = lw_q;

endmodule
